// File: rtl/chan_frame_serializer_if.sv
// -----------------------------------------------------------------------------
// chan_frame_serializer_if
//
// Byte-stream bus produced by chan_frame_serializer: an 8-bit valid/ready
// channel with start/end-of-frame markers.
//
// Signals:
//   out_data   8  frame byte
//   out_valid  1  out_data valid
//   out_ready  1  downstream accepts (a transfer is out_valid && out_ready)
//   out_sof    1  high with the sync byte
//   out_eof    1  high with the last byte of the frame
//
// Modports:
//   master  byte source (drives data/valid/sof/eof, samples ready)
//   slave   byte sink   (samples data/valid/sof/eof, drives ready)
// -----------------------------------------------------------------------------
interface chan_frame_serializer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_sof;
   logic       out_eof;

   modport master (
      output out_data,
      output out_valid,
      output out_sof,
      output out_eof,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_sof,
      input  out_eof,
      output out_ready
   );
endinterface

// File: rtl/chan_frame_serializer.sv
// -----------------------------------------------------------------------------
// chan_frame_serializer
//
// Captures one snapshot of NUM_CH 8-bit channel samples and streams it as a
// framed byte sequence:
//   SYNC_BYTE, seq_num, channel 0 .. channel NUM_CH-1 [, checksum]
//
// Optional feature macro: CHAN_FRAME_CHECKSUM_EN
//   defined   -> a checksum byte closes the frame; it is the two's complement
//                of (seq_num + sum of channel bytes) mod 256, so seq, payload
//                and checksum sum to 8'h00. out_eof marks the checksum byte.
//   undefined -> no checksum state or accumulator; out_eof marks the last
//                channel byte.
//
// Parameters:
//   NUM_CH     channels per snapshot (2..255)
//   SYNC_BYTE  first byte of every frame
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset (aborts any frame in flight)
//   sample_valid  one-cycle snapshot strobe (source cannot be stalled)
//   sample_data   snapshot, channel i in bits [8i+7:8i]
//   sample_ready  capture register empty (FSM idle)
//   out_bus       byte-stream master (out_data/out_valid/out_ready/sof/eof)
//   seq_num       sequence number of the current or next frame
//   dropped_cnt   snapshots lost while busy, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module chan_frame_serializer #(
   parameter int         NUM_CH    = 32,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sample_valid,
   input  logic [NUM_CH*8-1:0]      sample_data,
   output logic                     sample_ready,
   chan_frame_serializer_if.master  out_bus,
   output logic [7:0]               seq_num,
   output logic [15:0]              dropped_cnt
);

   localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

`ifdef CHAN_FRAME_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_SEQ,
      S_PAYLOAD,
      S_CSUM
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_SYNC,
      S_SEQ,
      S_PAYLOAD
   } state_t;
`endif

   state_t           state;
   logic [7:0]       cap [NUM_CH];
   logic [IDX_W-1:0] ch_idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [7:0]       data_r;
   logic             valid_r;
   logic             sof_r;
   logic             eof_r;
   logic             xfer;
`ifdef CHAN_FRAME_CHECKSUM_EN
   logic [7:0]       csum_acc;
`endif

   // Saturating 16-bit increment for the drop counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Two's complement of a running byte sum: the value that brings the
   // total back to 8'h00.
   function automatic logic [7:0] csum_close(input logic [7:0] sum);
      return 8'h00 - sum;
   endfunction

   // Outputs come straight from registers; out_ready only gates state
   // updates, so it never reaches out_valid/out_data combinationally.
   assign xfer              = valid_r && out_bus.out_ready;
   assign sample_ready      = (state == S_IDLE);
   assign idx_nxt           = ch_idx + 1'b1;
   assign out_bus.out_data  = data_r;
   assign out_bus.out_valid = valid_r;
   assign out_bus.out_sof   = sof_r;
   assign out_bus.out_eof   = eof_r;

   // Capture register: data only, no reset. Written only while idle, so a
   // snapshot arriving mid-frame never disturbs the frame being sent.
   always_ff @(posedge clk) begin
      if (sample_valid && sample_ready) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cap[i] <= sample_data[8*i +: 8];
         end
      end
   end

   // Drop counter: every strobe seen while busy is one lost snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         dropped_cnt <= 16'h0000;
      end else if (sample_valid && !sample_ready) begin
         dropped_cnt <= sat_inc16(dropped_cnt);
      end
   end

   // Framing FSM. Each state presents one byte; the byte for the next state
   // is loaded on the transfer edge so out_data is always registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         valid_r  <= 1'b0;
         data_r   <= 8'h00;
         sof_r    <= 1'b0;
         eof_r    <= 1'b0;
         seq_num  <= 8'h00;
         ch_idx   <= '0;
`ifdef CHAN_FRAME_CHECKSUM_EN
         csum_acc <= 8'h00;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (sample_valid) begin
                  state   <= S_SYNC;
                  valid_r <= 1'b1;
                  data_r  <= SYNC_BYTE;
                  sof_r   <= 1'b1;
                  eof_r   <= 1'b0;
               end
            end

            S_SYNC: begin
               if (xfer) begin
                  state    <= S_SEQ;
                  data_r   <= seq_num;
                  sof_r    <= 1'b0;
`ifdef CHAN_FRAME_CHECKSUM_EN
                  csum_acc <= seq_num;
`endif
               end
            end

            S_SEQ: begin
               if (xfer) begin
                  state  <= S_PAYLOAD;
                  ch_idx <= '0;
                  data_r <= cap[0];
                  eof_r  <= 1'b0;
               end
            end

            S_PAYLOAD: begin
               if (xfer) begin
                  if (ch_idx == LAST_IDX) begin
`ifdef CHAN_FRAME_CHECKSUM_EN
                     // Fold the last channel byte in while forming the checksum.
                     state   <= S_CSUM;
                     data_r  <= csum_close(csum_acc + data_r);
                     eof_r   <= 1'b1;
`else
                     state   <= S_IDLE;
                     valid_r <= 1'b0;
                     eof_r   <= 1'b0;
                     seq_num <= seq_num + 8'd1;
`endif
                  end else begin
                     ch_idx   <= idx_nxt;
                     data_r   <= cap[idx_nxt];
`ifdef CHAN_FRAME_CHECKSUM_EN
                     csum_acc <= csum_acc + data_r;
                     eof_r    <= 1'b0;
`else
                     eof_r    <= (idx_nxt == LAST_IDX);
`endif
                  end
               end
            end

`ifdef CHAN_FRAME_CHECKSUM_EN
            S_CSUM: begin
               if (xfer) begin
                  state   <= S_IDLE;
                  valid_r <= 1'b0;
                  eof_r   <= 1'b0;
                  seq_num <= seq_num + 8'd1;
               end
            end
`endif

            default: begin
               state   <= S_IDLE;
               valid_r <= 1'b0;
               sof_r   <= 1'b0;
               eof_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/chan_frame_serializer.md
# chan_frame_serializer

Upstream framing stage for the FPGA data path. It captures one snapshot of NUM_CH 8-bit channel samples and streams it as a framed byte sequence on an 8-bit valid/ready bus. That bus drives the design's `data_in`. Each frame is a sync byte, a sequence byte, then the channel payload, with an optional checksum byte at the end.

## Interface
- NUM_CH, 32: channels per snapshot (2..255)
- SYNC_BYTE, 8'hA5: first byte of every frame

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle snapshot strobe; the source cannot be stalled
- sample_data  in  NUM_CH*8  snapshot; channel i is in bits [8i+7:8i]
- sample_ready  out  1  capture register empty (state IDLE)
- out_data  out  8  frame byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_sof  out  1  high with the sync byte
- out_eof  out  1  high with the last byte of the frame
- seq_num  out  8  sequence number of the current or next frame
- dropped_cnt  out  16  snapshots lost, saturating

## Operation
- The block uses one capture register of NUM_CH*8 bits.
  - A snapshot is accepted when sample_valid && sample_ready.
  - The snapshot is latched, and the FSM leaves IDLE on the same edge.
- FSM states: IDLE → SYNC → SEQ → PAYLOAD → (CSUM) → IDLE.
  - Each state emits one byte and advances only on a transfer (out_valid && out_ready).
  - PAYLOAD uses a channel index of 0..NUM_CH-1 and advances to the next state after index NUM_CH-1 transfers.
- Byte order:
  - SYNC_BYTE.
  - seq_num.
  - Channels 0 through NUM_CH-1, in ascending index order.
  - The checksum, when the checksum feature is compiled in.
- seq_num increments by 1 on the transfer of the last byte of the frame. It wraps from 8'hFF to 8'h00.
- Drop counting:
  - Any cycle with sample_valid=1 and sample_ready=0 counts as one dropped snapshot.
  - dropped_cnt increments by 1 on that cycle and saturates at 16'hFFFF.
  - The capture register is left unchanged.
- out_data is driven from registers. While out_valid && !out_ready, out_data, out_sof and out_eof are held stable.
- out_valid is high in every state except IDLE.
- Reset values: out_valid=0, out_data=8'h00, out_sof=0, out_eof=0, seq_num=8'h00, dropped_cnt=16'h0000, FSM=IDLE, sample_ready=1.
- Reset asserted mid-frame aborts the frame immediately:
  - No further bytes are emitted.
  - seq_num is cleared.
  - The partially sent frame is not completed.

## Timing
- A snapshot accepted at edge N puts the sync byte on out_data with out_valid=1 from cycle N+1.
- With out_ready held at 1, one byte transfers per cycle.
  - Frame length: NUM_CH+2 bytes, or NUM_CH+3 bytes with the checksum.
- Transfer of the last byte at edge M returns the FSM to IDLE. sample_ready=1 in cycle M+1.
  - A sample_valid in cycle M itself counts as dropped.
  - Minimum snapshot period: NUM_CH+3 cycles, or NUM_CH+4 cycles with the checksum.
- sample_ready is a decode of the state register. It has no combinational path from any input.
- out_ready has no combinational path to out_valid or out_data.
- When a drop and a frame completion fall in the same cycle, both the counter update and the seq_num update take effect.

## Configuration
- The macro `CHAN_FRAME_CHECKSUM_EN` controls the checksum byte.
- When defined:
  - The CSUM state is present.
  - The checksum is the 8-bit two's complement of (seq_num + sum of all channel bytes) mod 256. Seq, payload and checksum therefore sum to 8'h00.
  - out_eof is asserted on the checksum byte.
- When undefined:
  - The CSUM state and its accumulator are absent.
  - out_eof is asserted on channel NUM_CH-1.

## Test plan
- Reset with out_ready=1 and no samples → out_valid=0, sample_ready=1, seq_num=0, dropped_cnt=0 for 10 cycles.
- One snapshot with channel i = i (NUM_CH=32), out_ready=1 → bytes A5, 00, 00, 01 … 1F; out_sof on A5.
  - With the checksum: a final byte 10 carrying out_eof.
  - Without the checksum: out_eof on 1F.
  - seq_num=1 afterwards.
- Same snapshot with out_ready toggling 1/0 every cycle → identical byte sequence. out_data and out_valid stay stable in every stalled cycle. 34 or 35 transfers, no duplicates.
- Strobe sample_valid on 5 separate cycles during one frame → dropped_cnt=5. The emitted payload equals the first snapshot.
- 256 back-to-back frames at the minimum period → seq bytes run 00..FF. seq_num returns to 00. dropped_cnt=0.
- Assert rst for 1 cycle after the 10th payload byte → out_valid=0 the next cycle, seq_num=0. The next snapshot emits a complete frame with seq byte 00.
